forward_hazard_ctrl: RTL and testbench
======================================

FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5: register-address width.
REQ-002 Parameter NUM_SRC, default 2, range 1..4: source operands per instruction.
REQ-003 Parameter ZERO_REG_EN, default 1: when 1, address 0 is never a forwarding or stall source.
REQ-004 Port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port id_valid  in  1  the ID stage holds a real instruction.
REQ-007 Port id_rs  in  NUM_SRC*ADDR_W  ID source addresses; operand k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 Port id_rd  in  ADDR_W  ID destination address.
REQ-009 Port id_regwrite  in  1  the ID instruction writes id_rd.
REQ-010 Port id_memread  in  1  the ID instruction is a load.
REQ-011 Port ex_busy  in  1  the EX multi-cycle unit is not done; freezes EX.
REQ-012 Port flush  in  1  kill the ID instruction (branch resolved in EX).
REQ-013 Port stall  out  1  hold PC and IF/ID this cycle.
REQ-014 Port fwd_sel  out  NUM_SRC*2  per-operand EX mux select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-015 Port ex_bubble  out  1  the EX entry is a bubble.

Function
REQ-016 Internal pipeline tags:
  - EX: valid, rd, regwrite, memread, rs[NUM_SRC].
  - MEM: valid, rd, regwrite, memread.
  - WB: valid, rd, regwrite.
REQ-017 A source is eligible only if its address is nonzero (when ZERO_REG_EN = 1) and the producing stage has valid = 1 and regwrite = 1.
REQ-018 fwd_sel[k] is combinational from registered tags:
  - 10 if MEM is eligible, MEM.rd == EX.rs[k] and MEM.memread == 0;
  - else 01 if WB is eligible and WB.rd == EX.rs[k];
  - else 00.
REQ-019 fwd_sel is all zeros whenever EX.valid = 0.
REQ-020 load_use is high when EX is eligible, EX.memread = 1, id_valid = 1 and EX.rd equals any id_rs[k] (nonzero when ZERO_REG_EN = 1).
REQ-021 stall = (load_use | ex_busy) & ~flush.
REQ-022 Each rising edge with ex_busy = 0:
  - WB takes MEM; MEM takes EX.
  - EX takes the ID fields, or a bubble (valid = 0, regwrite = 0, memread = 0) if flush, load_use or id_valid = 0.
REQ-023 Each rising edge with ex_busy = 1:
  - EX holds.
  - MEM takes a bubble; WB takes MEM.
  - If flush is also high, EX becomes a bubble.
REQ-024 flush has priority over load_use and ex_busy for EX contents.
REQ-025 Load-use stall lasts exactly one cycle per load: the next cycle the load is in MEM, and the consumer is served from WB by select 01.
REQ-026 ex_bubble = ~EX.valid.
REQ-027 All outputs settle combinationally within the cycle; there is no added latency beyond the tag registers.

Reset
REQ-028 rst_n low clears every valid, regwrite and memread bit immediately and asynchronously; address fields clear to 0.
REQ-029 During reset and after release: stall = 0, fwd_sel = 0, ex_bubble = 1.
REQ-030 Reset asserted mid-stall aborts the stall; the first post-reset edge loads EX from ID normally.

Configuration
REQ-031 Macro FWD_STALL_CNT_EN defined adds:
  - port stall_cnt  out  16  count of cycles with stall = 1;
  - the count saturates at 0xFFFF and clears on reset.
REQ-032 Macro FWD_STALL_CNT_EN undefined: no stall_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-033 Back-to-back ALU: add r3 then sub r5,r3,r4 -> while sub is in EX, fwd_sel[0] = 10, stall never asserts.
REQ-034 Two-apart: add r3, nop, or r6,r3,r3 -> fwd_sel = {01,01}; with both MEM and WB writing r3, MEM wins (10).
REQ-035 Load-use: lw r2 then add r4,r2,r1 -> stall = 1 for exactly one cycle with EX bubbled, then fwd_sel[0] = 01; under FWD_STALL_CNT_EN, stall_cnt = 1.
REQ-036 Zero register: add r0 then use r0 -> fwd_sel = 00 and no stall, even after lw r0.
REQ-037 ex_busy held 3 cycles with a dependent instruction in ID -> stall = 1 for 3 cycles, EX tags frozen, MEM receives 3 bubbles, then normal forwarding.
REQ-038 flush asserted during a load-use stall -> stall = 0 that cycle, EX becomes a bubble; reset pulse mid-sequence -> all outputs return to their REQ-029 values immediately.

Source files
------------

// File: rtl/forward_hazard_ctrl_if.sv
// rtl/forward_hazard_ctrl_if.sv - ID-stage/hazard-control signal bundle for forward_hazard_ctrl
interface forward_hazard_ctrl_if #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2
);
    logic                        id_valid;
    logic [NUM_SRC*ADDR_W-1:0]   id_rs;
    logic [ADDR_W-1:0]           id_rd;
    logic                        id_regwrite;
    logic                        id_memread;
    logic                        ex_busy;
    logic                        flush;
    logic                        stall;
    logic [NUM_SRC*2-1:0]        fwd_sel;
    logic                        ex_bubble;

    // pipeline side: presents the ID instruction and EX/branch status
    modport master (
        output id_valid, id_rs, id_rd, id_regwrite, id_memread, ex_busy, flush,
        input  stall, fwd_sel, ex_bubble
    );

    // hazard controller side
    modport slave (
        input  id_valid, id_rs, id_rd, id_regwrite, id_memread, ex_busy, flush,
        output stall, fwd_sel, ex_bubble
    );
endinterface

// File: rtl/forward_hazard_ctrl.sv
// rtl/forward_hazard_ctrl.sv - forwarding select and load-use/busy stall control (optional FWD_STALL_CNT_EN stall counter)
module forward_hazard_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int NUM_SRC     = 2,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    forward_hazard_ctrl_if.slave bus
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    logic                             ex_valid;
    logic                             ex_regwrite;
    logic                             ex_memread;
    logic [ADDR_W-1:0]                ex_rd;
    logic [NUM_SRC-1:0][ADDR_W-1:0]   ex_rs;

    logic                             mem_valid;
    logic                             mem_regwrite;
    logic                             mem_memread;
    logic [ADDR_W-1:0]                mem_rd;

    logic                             wb_valid;
    logic                             wb_regwrite;
    logic [ADDR_W-1:0]                wb_rd;

    logic                             ex_elig;
    logic                             mem_elig;
    logic                             wb_elig;
    logic                             load_use;
    logic                             ex_load;
    logic                             stall_c;
    logic [NUM_SRC*2-1:0]             fwd_sel_c;

    // register 0 is hardwired, so it never produces a value worth forwarding or waiting for
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (ZERO_REG_EN == 0) || (a != '0);
    endfunction

    assign ex_elig  = ex_valid  & ex_regwrite  & addr_ok(ex_rd);
    assign mem_elig = mem_valid & mem_regwrite & addr_ok(mem_rd);
    assign wb_elig  = wb_valid  & wb_regwrite  & addr_ok(wb_rd);

    // per-operand forwarding mux selects; the younger MEM result wins over WB, but a load in MEM has no data yet
    always_comb begin
        fwd_sel_c = '0;
        if (ex_valid) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (mem_elig && (mem_rd == ex_rs[k]) && !mem_memread)
                    fwd_sel_c[2*k +: 2] = 2'b10;
                else if (wb_elig && (wb_rd == ex_rs[k]))
                    fwd_sel_c[2*k +: 2] = 2'b01;
            end
        end
    end

    // a load in EX whose destination feeds any ID operand must hold ID one cycle
    always_comb begin
        load_use = 1'b0;
        if (ex_elig && ex_memread && bus.id_valid) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (bus.id_rs[k*ADDR_W +: ADDR_W] == ex_rd)
                    load_use = 1'b1;
            end
        end
    end

    // flush overrides any stall; stall is also forced low while reset is held so a busy EX unit cannot leak through
    assign stall_c       = rst_n & (load_use | bus.ex_busy) & ~bus.flush;
    assign ex_load       = bus.id_valid & ~bus.flush & ~load_use;
    assign bus.stall     = stall_c;
    assign bus.fwd_sel   = fwd_sel_c;
    assign bus.ex_bubble = ~ex_valid;

    // advance EX/MEM/WB tags; a busy EX freezes in place and feeds bubbles downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rd        <= '0;
            ex_rs        <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            wb_valid    <= mem_valid;
            wb_regwrite <= mem_regwrite;
            wb_rd       <= mem_rd;
            if (!bus.ex_busy) begin
                mem_valid    <= ex_valid;
                mem_regwrite <= ex_regwrite;
                mem_memread  <= ex_memread;
                mem_rd       <= ex_rd;
                ex_valid     <= ex_load;
                ex_regwrite  <= ex_load & bus.id_regwrite;
                ex_memread   <= ex_load & bus.id_memread;
                ex_rd        <= bus.id_rd;
                ex_rs        <= bus.id_rs;
            end else begin
                mem_valid    <= 1'b0;
                mem_regwrite <= 1'b0;
                mem_memread  <= 1'b0;
                if (bus.flush) begin
                    ex_valid    <= 1'b0;
                    ex_regwrite <= 1'b0;
                    ex_memread  <= 1'b0;
                end
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    // saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_c && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// tb/tb_forward_hazard_ctrl.sv - scoreboard bench for forward_hazard_ctrl with instruction-level pipeline model
module tb_forward_hazard_ctrl;
    localparam int AW = 5;
    localparam int NS = 2;

    typedef struct {
        bit          v;
        bit          rw;
        bit          mr;
        bit [AW-1:0] rd;
        bit [AW-1:0] rs0;
        bit [AW-1:0] rs1;
    } inst_t;

    typedef struct {
        bit        stall;
        bit [3:0]  fwd;
        bit        bubble;
        bit [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    forward_hazard_ctrl_if #(.ADDR_W(AW), .NUM_SRC(NS)) bus ();
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    forward_hazard_ctrl #(.ADDR_W(AW), .NUM_SRC(NS), .ZERO_REG_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    inst_t       blank = '{default: 0};
    inst_t       ex_i, mem_i, wb_i;
    int unsigned m_cnt;
    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;

    function automatic inst_t mk(bit v, bit rw, bit mr, bit [AW-1:0] rd, bit [AW-1:0] rs0, bit [AW-1:0] rs1);
        inst_t t;
        t.v = v; t.rw = rw; t.mr = mr; t.rd = rd; t.rs0 = rs0; t.rs1 = rs1;
        return t;
    endfunction

    // does instruction p deliver a usable result for register a
    function automatic bit writes(inst_t p, bit [AW-1:0] a);
        return p.v && p.rw && (a != 0) && (p.rd == a);
    endfunction

    // where the EX instruction should read register a from
    function automatic bit [1:0] src_for(bit [AW-1:0] a);
        if (!ex_i.v) return 2'b00;
        if (writes(mem_i, a) && !mem_i.mr) return 2'b10;
        if (writes(wb_i, a)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // one clock cycle: present ID, predict outputs, then move the instruction records on the edge
    task automatic step(input inst_t id, input bit busy, input bit fl, input bit rn, output bit st);
        bit   lu;
        exp_t e;
        rst_n           = rn;
        bus.id_valid    = id.v;
        bus.id_rs       = {id.rs1, id.rs0};
        bus.id_rd       = id.rd;
        bus.id_regwrite = id.rw;
        bus.id_memread  = id.mr;
        bus.ex_busy     = busy;
        bus.flush       = fl;
        if (!rn) begin
            ex_i = blank; mem_i = blank; wb_i = blank; m_cnt = 0;
        end
        lu       = id.v && ex_i.mr && (writes(ex_i, id.rs0) || writes(ex_i, id.rs1));
        e.stall  = rn && (lu || busy) && !fl;
        e.fwd    = {src_for(ex_i.rs1), src_for(ex_i.rs0)};
        e.bubble = !ex_i.v;
        e.cnt    = m_cnt[15:0];
        expq.push_back(e);
        st = e.stall;
        @(posedge clk);
        if (rn) begin
            if (e.stall && m_cnt < 65535) m_cnt++;
            wb_i = mem_i;
            if (!busy) begin
                mem_i = ex_i;
                ex_i  = (fl || lu || !id.v) ? blank : id;
            end else begin
                mem_i = blank;
                if (fl) ex_i = blank;
            end
        end
        #1;
    endtask

    // monitor: compare DUT outputs mid-cycle against the oldest outstanding prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall",     int'(bus.stall),     int'(e.stall));
                chk("fwd_sel",   int'(bus.fwd_sel),   int'(e.fwd));
                chk("ex_bubble", int'(bus.ex_bubble), int'(e.bubble));
`ifdef FWD_STALL_CNT_EN
                chk("stall_cnt", int'(stall_cnt),     int'(e.cnt));
`endif
            end
        end
    end

    initial begin
        inst_t nop, cur;
        bit    st, prev_st;
        nop = mk(1, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rd = '0; bus.id_regwrite = 0;
        bus.id_memread = 0; bus.ex_busy = 0; bus.flush = 0;
        ex_i = blank; mem_i = blank; wb_i = blank; m_cnt = 0;
        @(posedge clk); #1;

        // reset state, including a busy EX unit while reset is held
        step(nop, 0, 0, 0, st);
        step(nop, 1, 0, 0, st);

        // back-to-back ALU dependency
        step(mk(1, 1, 0, 3, 1, 2), 0, 0, 1, st);
        step(mk(1, 1, 0, 5, 3, 4), 0, 0, 1, st);
        repeat (3) step(nop, 0, 0, 1, st);

        // two-apart dependency, then MEM and WB both producing r3
        step(mk(1, 1, 0, 3, 1, 2), 0, 0, 1, st);
        step(nop, 0, 0, 1, st);
        step(mk(1, 1, 0, 6, 3, 3), 0, 0, 1, st);
        repeat (2) step(nop, 0, 0, 1, st);
        step(mk(1, 1, 0, 3, 1, 2), 0, 0, 1, st);
        step(mk(1, 1, 0, 3, 1, 1), 0, 0, 1, st);
        step(mk(1, 1, 0, 6, 3, 3), 0, 0, 1, st);
        repeat (3) step(nop, 0, 0, 1, st);

        // load-use: one stall cycle, consumer then served from WB
        step(mk(1, 1, 1, 2, 0, 0), 0, 0, 1, st);
        step(mk(1, 1, 0, 4, 2, 1), 0, 0, 1, st);
        step(mk(1, 1, 0, 4, 2, 1), 0, 0, 1, st);
        repeat (3) step(nop, 0, 0, 1, st);

        // zero register never forwards or stalls
        step(mk(1, 1, 0, 0, 1, 1), 0, 0, 1, st);
        step(mk(1, 1, 0, 7, 0, 0), 0, 0, 1, st);
        step(mk(1, 1, 1, 0, 0, 0), 0, 0, 1, st);
        step(mk(1, 1, 0, 7, 0, 0), 0, 0, 1, st);
        repeat (3) step(nop, 0, 0, 1, st);

        // EX busy for three cycles with a dependent instruction waiting in ID
        step(mk(1, 1, 0, 7, 1, 1), 0, 0, 1, st);
        step(mk(1, 1, 0, 8, 7, 0), 0, 0, 1, st);
        repeat (3) step(mk(1, 1, 0, 9, 8, 7), 1, 0, 1, st);
        step(mk(1, 1, 0, 9, 8, 7), 0, 0, 1, st);
        repeat (3) step(nop, 0, 0, 1, st);

        // flush during a load-use stall
        step(mk(1, 1, 1, 2, 0, 0), 0, 0, 1, st);
        step(mk(1, 1, 0, 4, 2, 1), 0, 1, 1, st);
        repeat (2) step(nop, 0, 0, 1, st);

        // reset pulse in the middle of a load-use stall, then normal load of EX
        step(mk(1, 1, 1, 2, 0, 0), 0, 0, 1, st);
        step(mk(1, 1, 0, 4, 2, 1), 1, 0, 0, st);
        step(mk(1, 1, 0, 4, 2, 1), 0, 0, 1, st);
        repeat (3) step(nop, 0, 0, 1, st);

        // randomized traffic; a stalled ID instruction is re-presented the next cycle
        prev_st = 0;
        cur = nop;
        for (int i = 0; i < 600; i++) begin
            bit busy, fl, rn, rw;
            if (!prev_st) begin
                rw  = ($urandom % 4) != 0;
                cur = mk(($urandom % 8) != 0, rw, rw && (($urandom % 3) == 0),
                         AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            end
            busy = ($urandom % 8) == 0;
            fl   = ($urandom % 10) == 0;
            rn   = ($urandom % 97) != 0;
            step(cur, busy, fl, rn, st);
            prev_st = st;
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
